// File: rtl/bus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_sram_responder
// Description : Scratchpad responder for the kianV valid/ready memory bus.
//               Decodes an address window, performs word reads and
//               byte-strobed writes on an internal word array, and
//               acknowledges with a one-cycle mem_ready after a fixed number
//               of wait states. Requests outside the window are ignored so
//               other responders on the same bus can answer them.
// Ports       : clk        - sole clock, rising edge
//               resetn     - synchronous active-low reset
//               mem_valid  - request valid, held until mem_ready
//               mem_addr   - byte address (bits [1:0] ignored)
//               mem_wstrb  - byte-lane write enables, 0 = read
//               mem_wdata  - write data
//               mem_ready  - one-cycle acknowledge
//               mem_rdata  - registered read data
//               busy       - high while a transaction is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module bus_sram_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned c_AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [c_AW-1:0]   idx_q, idx_d;
  logic [3:0]        strb_q, strb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q;

  logic              w_hit;
  logic [c_AW-1:0]   w_req_idx;
  logic              w_commit;
  logic [c_AW-1:0]   w_cidx;
  logic [3:0]        w_cstrb;
  logic [31:0]       w_cwdata;
  logic [31:0]       w_rd_word;
  logic              w_unused_addr;

  assign w_hit         = (mem_addr[31:c_AW+2] == BASE_ADDR[31:c_AW+2]);
  assign w_req_idx     = mem_addr[c_AW+1:2];
  assign w_unused_addr = ^mem_addr[1:0];

  // Next-state logic. The commit bundle (w_commit/w_cidx/w_cstrb/w_cwdata)
  // is asserted on the edge that enters ACK; with zero wait states that edge
  // is the sampling edge, so the live bus values are used instead of the
  // captured copies.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    wdata_d  = wdata_q;
    w_commit = 1'b0;
    w_cidx   = idx_q;
    w_cstrb  = strb_q;
    w_cwdata = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (mem_valid && w_hit) begin
          idx_d   = w_req_idx;
          strb_d  = mem_wstrb;
          wdata_d = mem_wdata;
          cnt_d   = c_WAIT_INIT;
          if (WAIT_STATES == 0) begin
            state_d  = ST_ACK;
            w_commit = 1'b1;
            w_cidx   = w_req_idx;
            w_cstrb  = mem_wstrb;
            w_cwdata = mem_wdata;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          // Initiator abort: drop the transaction without committing.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d  = ST_ACK;
            w_commit = 1'b1;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      strb_q  <= 4'd0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      if (w_commit && (w_cstrb == 4'b0000)) begin
        rdata_q <= w_rd_word;
      end
    end
  end

  // Storage is split into four byte-wide arrays so each lane has a single
  // writer; contents are deliberately not reset.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
      if (resetn && w_commit && w_cstrb[gi]) begin
        lane_q[w_cidx] <= w_cwdata[8*gi +: 8];
      end
    end

    assign w_rd_word[8*gi +: 8] = lane_q[w_cidx];
  end

  assign mem_ready = (state_q == ST_ACK);
  assign busy      = (state_q == ST_WAIT) || (state_q == ST_ACK);
  assign mem_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_sram_responder
// Description : Directed self-checking bench for bus_sram_responder. Five
//               instances cover the parameter sets exercised: W=1/BASE=0,
//               W=1/BASE=0x1000_0000, W=3, W=0 and W=2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_sram_responder;

  logic        clk;
  logic [4:0]  rstn;
  logic        v     [5];
  logic [31:0] addr  [5];
  logic [3:0]  strb  [5];
  logic [31:0] wdat  [5];
  logic [4:0]  rdy;
  logic [4:0]  bsy;
  logic [31:0] rdat  [5];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_sram_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_a (
    .clk(clk), .resetn(rstn[0]), .mem_valid(v[0]), .mem_addr(addr[0]), .mem_wstrb(strb[0]),
    .mem_wdata(wdat[0]), .mem_ready(rdy[0]), .mem_rdata(rdat[0]), .busy(bsy[0]));
  bus_sram_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(1)) u_b (
    .clk(clk), .resetn(rstn[1]), .mem_valid(v[1]), .mem_addr(addr[1]), .mem_wstrb(strb[1]),
    .mem_wdata(wdat[1]), .mem_ready(rdy[1]), .mem_rdata(rdat[1]), .busy(bsy[1]));
  bus_sram_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u_c (
    .clk(clk), .resetn(rstn[2]), .mem_valid(v[2]), .mem_addr(addr[2]), .mem_wstrb(strb[2]),
    .mem_wdata(wdat[2]), .mem_ready(rdy[2]), .mem_rdata(rdat[2]), .busy(bsy[2]));
  bus_sram_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u_d (
    .clk(clk), .resetn(rstn[3]), .mem_valid(v[3]), .mem_addr(addr[3]), .mem_wstrb(strb[3]),
    .mem_wdata(wdat[3]), .mem_ready(rdy[3]), .mem_rdata(rdat[3]), .busy(bsy[3]));
  bus_sram_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(2)) u_e (
    .clk(clk), .resetn(rstn[4]), .mem_valid(v[4]), .mem_addr(addr[4]), .mem_wstrb(strb[4]),
    .mem_wdata(wdat[4]), .mem_ready(rdy[4]), .mem_rdata(rdat[4]), .busy(bsy[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance k. Inputs change on the falling
  // edge; latency counts falling edges from request to mem_ready.
  task automatic txn(input int k, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input int exp_lat, input string tag,
                     output logic [31:0] rd);
    int lat;
    bit got;
    @(negedge clk);
    v[k] = 1'b1; addr[k] = a; strb[k] = s; wdat[k] = d;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rdy[k]) got = 1'b1;
    end
    rd = rdat[k];
    v[k] = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
    chk({tag, "_ready_width"}, {31'h0, rdy[k]}, 32'h0);
  endtask

  // Present a request that must be ignored and watch for 20 cycles.
  task automatic miss(input int k, input logic [31:0] a, input string tag);
    bit saw_rdy;
    bit saw_bsy;
    @(negedge clk);
    v[k] = 1'b1; addr[k] = a; strb[k] = 4'h0; wdat[k] = 32'h0;
    saw_rdy = 1'b0;
    saw_bsy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy[k]) saw_rdy = 1'b1;
      if (bsy[k]) saw_bsy = 1'b1;
    end
    v[k] = 1'b0;
    chk({tag, "_no_ready"}, {31'h0, saw_rdy}, 32'h0);
    chk({tag, "_no_busy"}, {31'h0, saw_bsy}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    bit got;

    rstn = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      v[k] = 1'b0; addr[k] = 32'h0; strb[k] = 4'h0; wdat[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    rstn = 5'b11111;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'h0, rdy[0]}, 32'h0);
      chk("idle_busy",  {31'h0, bsy[0]}, 32'h0);
      chk("idle_rdata", rdat[0], 32'h0);
    end

    // Full-word write then read, W=1.
    txn(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 2, "w1_write", rd);
    chk("w1_write_rdata_unchanged", rdat[0], 32'h0);
    txn(0, 32'h10, 4'h0, 32'h0, 2, "w1_read", rd);
    chk("w1_read_data", rd, 32'hDEAD_BEEF);
    chk("w1_read_data_held", rdat[0], 32'hDEAD_BEEF);

    // Single-lane write.
    txn(0, 32'h10, 4'b0100, 32'h00AA_0000, 2, "strb_write", rd);
    chk("strb_write_rdata_held", rdat[0], 32'hDEAD_BEEF);
    txn(0, 32'h10, 4'h0, 32'h0, 2, "strb_read", rd);
    chk("strb_read_data", rd, 32'hDEAA_BEEF);

    // Window decode with BASE=0x1000_0000.
    miss(1, 32'h2000_0000, "miss_far");
    txn(1, 32'h1000_03FC, 4'hF, 32'hCAFE_F00D, 2, "top_write", rd);
    txn(1, 32'h1000_03FC, 4'h0, 32'h0, 2, "top_read", rd);
    chk("top_read_data", rd, 32'hCAFE_F00D);
    miss(1, 32'h1000_0400, "miss_above");
    chk("miss_rdata_held", rdat[1], 32'hCAFE_F00D);

    // Abort during WAIT, W=3.
    txn(2, 32'h20, 4'hF, 32'h1111_1111, 4, "w3_init20", rd);
    txn(2, 32'h24, 4'hF, 32'h2424_2424, 4, "w3_init24", rd);
    @(negedge clk);
    v[2] = 1'b1; addr[2] = 32'h20; strb[2] = 4'hF; wdat[2] = 32'h1234_5678;
    @(negedge clk);
    chk("abort_busy_in_wait", {31'h0, bsy[2]}, 32'h1);
    v[2] = 1'b0;
    @(negedge clk);
    chk("abort_back_to_idle", {31'h0, bsy[2]}, 32'h0);
    chk("abort_no_ready", {31'h0, rdy[2]}, 32'h0);
    repeat (3) @(negedge clk);
    chk("abort_no_late_ready", {31'h0, rdy[2]}, 32'h0);
    txn(2, 32'h20, 4'h0, 32'h0, 4, "abort_read", rd);
    chk("abort_read_old_value", rd, 32'h1111_1111);

    // Back-to-back reads: mem_valid stays high across the acknowledge.
    @(negedge clk);
    v[2] = 1'b1; addr[2] = 32'h20; strb[2] = 4'h0;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[2]) got = 1'b1;
    end
    chk("b2b_first_latency", 32'(n), 32'd4);
    chk("b2b_first_data", rdat[2], 32'h1111_1111);
    addr[2] = 32'h24;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (rdy[2]) got = 1'b1;
    end
    v[2] = 1'b0;
    chk("b2b_ack_spacing", 32'(n), 32'd5);
    chk("b2b_second_data", rdat[2], 32'h2424_2424);

    // Zero wait states.
    txn(3, 32'h40, 4'hF, 32'hA5A5_A5A5, 1, "w0_write", rd);
    txn(3, 32'h40, 4'h0, 32'h0, 1, "w0_read", rd);
    chk("w0_read_data", rd, 32'hA5A5_A5A5);

    // Reset during WAIT, W=2.
    txn(4, 32'h30, 4'hF, 32'h0BAD_F00D, 3, "w2_init", rd);
    txn(4, 32'h30, 4'h0, 32'h0, 3, "w2_preread", rd);
    chk("w2_preread_data", rd, 32'h0BAD_F00D);
    @(negedge clk);
    v[4] = 1'b1; addr[4] = 32'h30; strb[4] = 4'hF; wdat[4] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_busy_in_wait", {31'h0, bsy[4]}, 32'h1);
    rstn[4] = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, rdy[4]}, 32'h0);
    chk("rst_busy",  {31'h0, bsy[4]}, 32'h0);
    chk("rst_rdata", rdat[4], 32'h0);
    v[4] = 1'b0;
    rstn[4] = 1'b1;
    @(negedge clk);
    txn(4, 32'h30, 4'h0, 32'h0, 3, "rst_read", rd);
    chk("rst_read_no_commit", rd, 32'h0BAD_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global safety net so the run can never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
